press_event_arbiter: RTL and testbench

Front-end controller for the board push-buttons. Each raw press line gets its own press-detect channel with a low-time re-arm lockout, so a bouncing contact yields one event per press. The block queues at most one pending event per button and serializes all pending events onto one valid/ready event port using round-robin arbitration. It sits between the synchronized button inputs and the control FSM that consumes button commands.

---
 rtl/press_event_arbiter.sv | 146 ++++++++++++++
 tb/tb_press_event_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/press_event_arbiter.sv
// press_event_arbiter
// Per-button press detection with a low-time re-arm lockout, one pending
// event per button, and round-robin serialization onto a single event port.
//
// Event port handshake: an event transfers on a rising edge where
// evtValid=1 and evtReady=1. While evtValid=1 and evtReady=0, evtId is held
// stable and no new grant is made. evtReady has no effect while evtValid=0.
module press_event_arbiter #(
  parameter int NUM_BTN = 4,
  parameter int HOLDOFF = 16,
  parameter int ID_W    = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] inPress,
  input  logic               evtReady,
  output logic               evtValid,
  output logic [ID_W-1:0]    evtId,
  output logic [NUM_BTN-1:0] pendingMask,
  output logic               overrun
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } chan_state_t;

  // Counter reload so that re-arming takes exactly HOLDOFF low cycles.
  localparam logic [7:0] RELOAD = 8'(HOLDOFF - 1);

  chan_state_t        state_q [NUM_BTN];
  chan_state_t        state_d [NUM_BTN];
  logic [7:0]         cnt_q   [NUM_BTN];
  logic [7:0]         cnt_d   [NUM_BTN];

  // Flat view of the channel FSMs (1 = HOLD), handy for probing.
  logic [NUM_BTN-1:0] chan_hold;
  logic [NUM_BTN-1:0] detect;

  logic               out_free;
  logic               grant_any;
  logic [ID_W-1:0]    grant_idx;
  logic [NUM_BTN-1:0] grant_vec;
  logic [ID_W-1:0]    ptr_q;
  logic [ID_W-1:0]    ptr_next;
  logic [NUM_BTN-1:0] pend_d;
  logic               overrun_d;

  // Channel FSM next-state: detect on a high level while IDLE, lockout in HOLD.
  always_comb begin
    for (int i = 0; i < NUM_BTN; i++) begin
      state_d[i]   = state_q[i];
      cnt_d[i]     = cnt_q[i];
      chan_hold[i] = (state_q[i] == HOLD);
      detect[i]    = inPress[i] && (state_q[i] == IDLE);
      case (state_q[i])
        IDLE: begin
          if (inPress[i]) begin
            state_d[i] = HOLD;
            cnt_d[i]   = RELOAD;
          end
        end
        HOLD: begin
          if (inPress[i]) begin
            cnt_d[i] = RELOAD;
          end else if (cnt_q[i] != 8'd0) begin
            cnt_d[i] = cnt_q[i] - 8'd1;
          end else begin
            state_d[i] = IDLE;
          end
        end
      endcase
    end
  end

  // Channel FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_BTN; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= 8'd0;
      end
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // Round-robin grant: first pending bit at or above the pointer, then wrap
  // to the bits below it. Only evaluated when the output register is free.
  always_comb begin
    out_free  = !evtValid || evtReady;
    grant_any = 1'b0;
    grant_idx = '0;
    grant_vec = '0;
    if (out_free) begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if (!grant_any && pendingMask[i] && (ID_W'(i) >= ptr_q)) begin
          grant_any    = 1'b1;
          grant_idx    = ID_W'(i);
          grant_vec[i] = 1'b1;
        end
      end
      for (int i = 0; i < NUM_BTN; i++) begin
        if (!grant_any && pendingMask[i] && (ID_W'(i) < ptr_q)) begin
          grant_any    = 1'b1;
          grant_idx    = ID_W'(i);
          grant_vec[i] = 1'b1;
        end
      end
    end
    if (grant_idx == ID_W'(NUM_BTN - 1)) begin
      ptr_next = '0;
    end else begin
      ptr_next = grant_idx + ID_W'(1);
    end
    // A same-cycle detect re-sets a flag being granted; an overrun is only a
    // detect landing on a flag that stays set.
    pend_d    = (pendingMask & ~grant_vec) | detect;
    overrun_d = |(detect & pendingMask & ~grant_vec);
  end

  // Pending flags, overrun pulse, output register and arbitration pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      pendingMask <= '0;
      overrun     <= 1'b0;
      evtValid    <= 1'b0;
      evtId       <= '0;
      ptr_q       <= '0;
    end else begin
      pendingMask <= pend_d;
      overrun     <= overrun_d;
      if (out_free) begin
        evtValid <= grant_any;
        if (grant_any) begin
          evtId <= grant_idx;
          ptr_q <= ptr_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_press_event_arbiter.sv
// Testbench for press_event_arbiter: directed scenarios plus randomized
// traffic checked against a cycle-level behavioural model.
module tb_press_event_arbiter;

  localparam int NUM_BTN = 4;
  localparam int HOLDOFF = 16;
  localparam int ID_W    = 2;

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset;
  logic [NUM_BTN-1:0] in_press;
  logic               evt_ready;
  logic               evt_valid;
  logic [ID_W-1:0]    evt_id;
  logic [NUM_BTN-1:0] pending_mask;
  logic               overrun;

  press_event_arbiter #(
    .NUM_BTN(NUM_BTN),
    .HOLDOFF(HOLDOFF),
    .ID_W   (ID_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .inPress    (in_press),
    .evtReady   (evt_ready),
    .evtValid   (evt_valid),
    .evtId      (evt_id),
    .pendingMask(pending_mask),
    .overrun    (overrun)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard: ids the model granted, in order, awaiting acceptance.
  logic [ID_W-1:0] exp_q[$];
  // Log of ids the DUT actually handed over (valid and ready at an edge).
  logic [ID_W-1:0] acc_ids[$];

  // Behavioural model: a channel is armed once it has seen HOLDOFF lows in a
  // row since its last high sample (or since reset).
  int                 low_run [NUM_BTN];
  logic [NUM_BTN-1:0] m_pend;
  logic               m_valid;
  logic [ID_W-1:0]    m_id;
  int                 m_ptr;
  logic               m_ovr;

  wire [7:0] dut_vec = {evt_valid, evt_id, pending_mask, overrun};
  wire [7:0] mdl_vec = {m_valid, m_id, m_pend, m_ovr};

  function automatic void model_update(input logic [NUM_BTN-1:0] p, input logic r, input logic rst);
    logic [NUM_BTN-1:0] det;
    logic [NUM_BTN-1:0] g;
    int gi;
    if (rst) begin
      m_pend  = '0;
      m_valid = 1'b0;
      m_id    = '0;
      m_ptr   = 0;
      m_ovr   = 1'b0;
      for (int i = 0; i < NUM_BTN; i++) low_run[i] = HOLDOFF;
      exp_q.delete();
      return;
    end
    det = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (p[i] && low_run[i] >= HOLDOFF) det[i] = 1'b1;
      if (p[i]) low_run[i] = 0;
      else if (low_run[i] < HOLDOFF) low_run[i] = low_run[i] + 1;
    end
    g  = '0;
    gi = -1;
    if (!m_valid || r) begin
      for (int k = 0; k < NUM_BTN; k++) begin
        if (gi < 0 && m_pend[(m_ptr + k) % NUM_BTN]) gi = (m_ptr + k) % NUM_BTN;
      end
      if (gi >= 0) begin
        g[gi]   = 1'b1;
        m_valid = 1'b1;
        m_id    = ID_W'(gi);
        m_ptr   = (gi + 1) % NUM_BTN;
        exp_q.push_back(ID_W'(gi));
      end else begin
        m_valid = 1'b0;
      end
    end
    m_ovr  = |(det & m_pend & ~g);
    m_pend = (m_pend & ~g) | det;
  endfunction

  // Driver: apply one cycle of inputs, score any handshake, advance the model.
  task automatic step(input logic [NUM_BTN-1:0] p, input logic r, input logic rst);
    logic [ID_W-1:0] e;
    in_press  = p;
    evt_ready = r;
    reset     = rst;
    if (!rst && evt_valid === 1'b1 && r) begin
      acc_ids.push_back(evt_id);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_accept got id=%0d expected no event", evt_id);
      end else begin
        e = exp_q.pop_front();
        if (evt_id !== e) begin
          errors++;
          $display("FAIL sb_order got id=%0d expected id=%0d", evt_id, e);
        end
      end
    end
    model_update(p, r, rst);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step('0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b1);
    checks++;
    if (dut_vec !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs got=%b expected=%b", dut_vec, 8'h00);
    end
  endtask

  task automatic test_single_press();
    step(4'b0000, 1'b1, 1'b0);
    step(4'b0100, 1'b1, 1'b0);
    checks++;
    if ({evt_valid, pending_mask, overrun} !== {1'b0, 4'b0100, 1'b0}) begin
      errors++;
      $display("FAIL single_detect got v=%b pend=%b ovr=%b expected v=0 pend=0100 ovr=0",
               evt_valid, pending_mask, overrun);
    end
    step(4'b0000, 1'b1, 1'b0);
    checks++;
    if ({evt_valid, evt_id, pending_mask, overrun} !== {1'b1, 2'd2, 4'b0000, 1'b0}) begin
      errors++;
      $display("FAIL single_event got v=%b id=%0d pend=%b ovr=%b expected v=1 id=2 pend=0000 ovr=0",
               evt_valid, evt_id, pending_mask, overrun);
    end
    step(4'b0000, 1'b1, 1'b0);
    checks++;
    if (evt_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_one_cycle got v=%b expected v=0", evt_valid);
    end
    repeat (20) step(4'b0000, 1'b1, 1'b0);
  endtask

  task automatic test_bounce();
    acc_ids.delete();
    for (int k = 0; k < 5; k++) step((k % 2 == 0) ? 4'b0010 : 4'b0000, 1'b1, 1'b0);
    repeat (20) step(4'b0000, 1'b1, 1'b0);
    checks++;
    if (acc_ids.size() != 1 || acc_ids[0] !== 2'd1) begin
      errors++;
      $display("FAIL bounce_single got %0d events expected 1 event id=1", acc_ids.size());
    end
    acc_ids.delete();
    step(4'b0010, 1'b1, 1'b0);
    repeat (HOLDOFF - 2) step(4'b0000, 1'b1, 1'b0);
    step(4'b0010, 1'b1, 1'b0);
    checks++;
    if (pending_mask !== 4'b0000) begin
      errors++;
      $display("FAIL bounce_early_press got pend=%b expected pend=0000", pending_mask);
    end
    repeat (HOLDOFF) step(4'b0000, 1'b1, 1'b0);
    step(4'b0010, 1'b1, 1'b0);
    checks++;
    if (pending_mask !== 4'b0010) begin
      errors++;
      $display("FAIL bounce_rearm got pend=%b expected pend=0010", pending_mask);
    end
    repeat (20) step(4'b0000, 1'b1, 1'b0);
    checks++;
    if (acc_ids.size() != 2) begin
      errors++;
      $display("FAIL bounce_count got %0d events expected 2", acc_ids.size());
    end
  endtask

  task automatic test_simultaneous();
    step('0, 1'b1, 1'b1);
    for (int rnd = 0; rnd < 2; rnd++) begin
      step(4'b1111, 1'b1, 1'b0);
      for (int k = 0; k < 4; k++) begin
        step(4'b0000, 1'b1, 1'b0);
        checks++;
        if (evt_valid !== 1'b1 || evt_id !== ID_W'(k)) begin
          errors++;
          $display("FAIL simul_order round=%0d got v=%b id=%0d expected v=1 id=%0d",
                   rnd, evt_valid, evt_id, k);
        end
      end
      repeat (17) step(4'b0000, 1'b1, 1'b0);
    end
    // Leave the pointer at 2 (last grant 1), then check wrap ordering.
    step(4'b0011, 1'b1, 1'b0);
    repeat (20) step(4'b0000, 1'b1, 1'b0);
    step(4'b0011, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      step(4'b0000, 1'b1, 1'b0);
      checks++;
      if (evt_valid !== 1'b1 || evt_id !== ID_W'(k)) begin
        errors++;
        $display("FAIL simul_wrap got v=%b id=%0d expected v=1 id=%0d", evt_valid, evt_id, k);
      end
    end
    repeat (20) step(4'b0000, 1'b1, 1'b0);
  endtask

  task automatic test_backpressure();
    step(4'b1000, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step(4'b0001, 1'b0, 1'b0);
      checks++;
      if (evt_valid !== 1'b1 || evt_id !== 2'd3 || pending_mask !== 4'b0001) begin
        errors++;
        $display("FAIL bp_hold cyc=%0d got v=%b id=%0d pend=%b expected v=1 id=3 pend=0001",
                 k, evt_valid, evt_id, pending_mask);
      end
    end
    step(4'b0000, 1'b1, 1'b0);
    checks++;
    if (evt_valid !== 1'b1 || evt_id !== 2'd0 || pending_mask !== 4'b0000) begin
      errors++;
      $display("FAIL bp_release got v=%b id=%0d pend=%b expected v=1 id=0 pend=0000",
               evt_valid, evt_id, pending_mask);
    end
    repeat (20) step(4'b0000, 1'b1, 1'b0);
  endtask

  task automatic test_overrun();
    step(4'b1000, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    step(4'b0100, 1'b0, 1'b0);
    repeat (HOLDOFF + 1) step(4'b0000, 1'b0, 1'b0);
    step(4'b0100, 1'b0, 1'b0);
    checks++;
    if (overrun !== 1'b1 || pending_mask !== 4'b0100) begin
      errors++;
      $display("FAIL overrun_pulse got ovr=%b pend=%b expected ovr=1 pend=0100", overrun, pending_mask);
    end
    step(4'b0000, 1'b0, 1'b0);
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_width got ovr=%b expected ovr=0", overrun);
    end
    acc_ids.delete();
    repeat (20) step(4'b0000, 1'b1, 1'b0);
    checks++;
    if (acc_ids.size() != 2 || acc_ids[0] !== 2'd3 || acc_ids[1] !== 2'd2) begin
      errors++;
      $display("FAIL overrun_delivery got %0d events expected 2 (ids 3 then 2)", acc_ids.size());
    end
  endtask

  task automatic test_reset_mid();
    step(4'b0001, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    step(4'b0110, 1'b0, 1'b0);
    checks++;
    if (evt_valid !== 1'b1 || pending_mask !== 4'b0110) begin
      errors++;
      $display("FAIL rmid_setup got v=%b pend=%b expected v=1 pend=0110", evt_valid, pending_mask);
    end
    step(4'b0110, 1'b0, 1'b1);
    checks++;
    if (dut_vec !== 8'h00) begin
      errors++;
      $display("FAIL rmid_clear got=%b expected=%b", dut_vec, 8'h00);
    end
    step(4'b0110, 1'b0, 1'b0);
    checks++;
    if (evt_valid !== 1'b0 || pending_mask !== 4'b0110) begin
      errors++;
      $display("FAIL rmid_redetect got v=%b pend=%b expected v=0 pend=0110", evt_valid, pending_mask);
    end
    step(4'b0110, 1'b1, 1'b0);
    checks++;
    if (evt_valid !== 1'b1 || evt_id !== 2'd1) begin
      errors++;
      $display("FAIL rmid_first_grant got v=%b id=%0d expected v=1 id=1", evt_valid, evt_id);
    end
    repeat (20) step(4'b0000, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    logic [NUM_BTN-1:0] p;
    logic r;
    int dens;
    step('0, 1'b1, 1'b1);
    dens = 30;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) dens = ($urandom_range(0, 1) == 0) ? 3 : 30;
      for (int i = 0; i < NUM_BTN; i++) p[i] = ($urandom_range(0, dens - 1) == 0);
      r = ($urandom_range(0, 3) != 0);
      step(p, r, (c == 1500));
      checks++;
      if (dut_vec !== mdl_vec) begin
        errors++;
        $display("FAIL rand_model cyc=%0d got v,id,pend,ovr=%b expected=%b", c, dut_vec, mdl_vec);
      end
    end
    for (int c = 0; c < 40; c++) begin
      step('0, 1'b1, 1'b0);
      checks++;
      if (dut_vec !== mdl_vec) begin
        errors++;
        $display("FAIL rand_drain cyc=%0d got=%b expected=%b", c, dut_vec, mdl_vec);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rand_leftover got %0d undelivered events expected 0", exp_q.size());
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_press  = '0;
    evt_ready = 1'b0;
    test_reset();
    test_single_press();
    test_bounce();
    test_simultaneous();
    test_backpressure();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
